// File: rtl/wf_rr_arbiter_16_pkg.sv
// Shared constants and the rotate helper for the wavefront round-robin arbiter.
package wf_rr_arbiter_16_pkg;

    localparam int WF_SLOTS = 16;
    localparam int WF_ID_W  = 4;

    typedef logic [WF_SLOTS-1:0] wf_vec_t;
    typedef logic [WF_ID_W-1:0]  wf_id_t;

    // Result bit i takes v[(i+s) mod 16], so the pointer slot lands on bit 0.
    function automatic wf_vec_t wf_rotr(input wf_vec_t v, input wf_id_t s);
        logic [2*WF_SLOTS-1:0] dbl;
        dbl = {v, v} >> s;
        return dbl[WF_SLOTS-1:0];
    endfunction

endpackage

// File: rtl/wf_rr_arbiter_16_if.sv
// Request/grant bundle between wavefront slots, the arbiter and the issue consumer.
interface wf_rr_arbiter_16_if;
    import wf_rr_arbiter_16_pkg::*;

    wf_vec_t req;
    logic    flush;
    logic    grant_ready;
    logic    grant_valid;
    wf_id_t  grant_id;
    wf_vec_t grant_onehot;

    modport master (
        input  req, flush, grant_ready,
        output grant_valid, grant_id, grant_onehot
    );

    modport slave (
        output req, flush, grant_ready,
        input  grant_valid, grant_id, grant_onehot
    );

endinterface

// File: rtl/wf_rr_arbiter_16_penc.sv
// 16-to-4 priority encoder: lowest set index wins; output is zero when disabled.
module priority_encoder_16_to_4 (
    input  logic        en_i,
    input  logic [15:0] req_i,
    output logic [3:0]  enc_o
);

    always_comb begin
        enc_o = 4'd0;
        if (en_i) begin
            for (int i = 15; i >= 0; i--) begin
                if (req_i[i]) enc_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/wf_rr_arbiter_16.sv
// Round-robin arbiter over 16 wavefront slots with a registered valid/ready grant.
// Optional stall counter port enabled by defining WF_ARB_PERF_CNT_EN.
module wf_rr_arbiter_16
    import wf_rr_arbiter_16_pkg::*;
#(
    parameter logic [3:0] RESET_PTR = 4'd0
`ifdef WF_ARB_PERF_CNT_EN
    ,
    parameter int PERF_CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic rst,
    wf_rr_arbiter_16_if.master bus
`ifdef WF_ARB_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state_q, state_d;
    wf_id_t     id_q, id_d;
    wf_vec_t    oh_q, oh_d;
    wf_id_t     ptr_q, ptr_d;

    logic    hs;
    wf_vec_t m;
    wf_id_t  p;
    wf_vec_t rot;
    logic    en;
    wf_id_t  enc;
    wf_id_t  win;

    assign hs  = (state_q == HOLD) & bus.grant_ready;
    // The slot accepted this cycle sits out so it cannot win twice in a row.
    assign m   = bus.req & ~(hs ? oh_q : '0);
    assign p   = hs ? id_q + 4'd1 : ptr_q;
    assign rot = wf_rotr(m, p);
    assign en  = |rot;
    assign win = enc + p;

    priority_encoder_16_to_4 u_penc (
        .en_i  (en),
        .req_i (rot),
        .enc_o (enc)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        oh_d    = oh_q;
        ptr_d   = hs ? id_q + 4'd1 : ptr_q;
        if (bus.flush) begin
            state_d = IDLE;
            oh_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = HOLD;
                        id_d    = win;
                        oh_d    = wf_vec_t'(1) << win;
                    end
                end
                HOLD: begin
                    if (hs && en) begin
                        id_d = win;
                        oh_d = wf_vec_t'(1) << win;
                    end else if (hs) begin
                        state_d = IDLE;
                        oh_d    = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    oh_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            oh_q    <= '0;
            ptr_q   <= RESET_PTR;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant_valid  = (state_q == HOLD);
    assign bus.grant_id     = id_q;
    assign bus.grant_onehot = oh_q;

`ifdef WF_ARB_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == HOLD) && !bus.grant_ready && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_wf_rr_arbiter_16.sv
// Randomized and directed checks of wf_rr_arbiter_16 against a slot-scanning model.
module tb_wf_rr_arbiter_16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        flush;
    logic        ready;

    int checks = 0;
    int errors = 0;

    wf_rr_arbiter_16_if bus ();

    assign bus.req         = req;
    assign bus.flush       = flush;
    assign bus.grant_ready = ready;

`ifdef WF_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt;
    wf_rr_arbiter_16 dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
    wf_rr_arbiter_16 dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: is a grant held, which slot, and who is first in line.
    bit          mv;
    int          mid;
    int          mptr;
    logic [31:0] mstall;

    function automatic logic [15:0] model_oh();
        logic [15:0] v;
        v = 16'h0;
        if (mv) v[mid] = 1'b1;
        return v;
    endfunction

    task automatic step();
        bit hs;
        int start;
        bit nv;
        int nid;
        int nptr;
        hs   = mv && ready;
        nptr = hs ? (mid + 1) % 16 : mptr;
        start = nptr;
        nv   = mv;
        nid  = mid;
        if (flush) begin
            nv = 0;
        end else if (!mv || hs) begin
            nv = 0;
            for (int k = 0; k < 16; k++) begin
                int j;
                j = (start + k) % 16;
                if (!nv && req[j] && !(hs && j == mid)) begin
                    nv  = 1;
                    nid = j;
                end
            end
        end
        if (!rst && mv && !ready && mstall != 32'hFFFF_FFFF)
            mstall = mstall + 1;
        @(posedge clk);
        #1;
        if (rst) begin
            mv = 0; mid = 0; mptr = 0; mstall = 0;
        end else begin
            mv = nv; mid = nid; mptr = nptr;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 16'h0; flush = 1'b0; ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 16'h0; flush = 1'b0; ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 16'h0 ||
                bus.grant_id !== 4'd0) begin
                errors++;
                $display("FAIL reset v=%b id=%0d oh=%h want 0/0/0",
                         bus.grant_valid, bus.grant_id, bus.grant_onehot);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_alternate();
        do_reset();
        req = 16'h8001; ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] want;
            want = (c % 2 == 0) ? 4'd0 : 4'd15;
            step();
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== want ||
                bus.grant_onehot !== model_oh() || mid != int'(want)) begin
                errors++;
                $display("FAIL alternate c=%0d v=%b id=%0d oh=%h want id=%0d",
                         c, bus.grant_valid, bus.grant_id, bus.grant_onehot, want);
            end
        end
    endtask

    task automatic test_stall();
        int seq[4] = '{5, 6, 7, 4};
        do_reset();
        req = 16'h00F0; ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== 4'd4 ||
                bus.grant_onehot !== 16'h0010) begin
                errors++;
                $display("FAIL stall_hold v=%b id=%0d oh=%h want 1/4/0010",
                         bus.grant_valid, bus.grant_id, bus.grant_onehot);
            end
        end
`ifdef WF_ARB_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd4 || mstall != 32'd4) begin
            errors++;
            $display("FAIL stall_cnt got %0d want 4", stall_cnt);
        end
`endif
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.grant_valid !== 1'b1 || int'(bus.grant_id) != seq[c]) begin
                errors++;
                $display("FAIL stall_release c=%0d v=%b id=%0d want %0d",
                         c, bus.grant_valid, bus.grant_id, seq[c]);
            end
        end
    endtask

    task automatic test_wrap();
        int seq[4] = '{14, 1, 14, 1};
        do_reset();
        req = 16'h4000; ready = 1'b1;
        step();
        req = 16'h4002;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            checks++;
            if (bus.grant_valid !== 1'b1 || int'(bus.grant_id) != seq[c] ||
                bus.grant_onehot !== model_oh()) begin
                errors++;
                $display("FAIL wrap c=%0d v=%b id=%0d oh=%h want %0d",
                         c, bus.grant_valid, bus.grant_id, bus.grant_onehot, seq[c]);
            end
        end
    endtask

    task automatic test_single();
        bit want_v[4] = '{1, 0, 1, 0};
        do_reset();
        req = 16'h0008; ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.grant_valid !== want_v[c] ||
                bus.grant_onehot !== (want_v[c] ? 16'h0008 : 16'h0) ||
                (want_v[c] && bus.grant_id !== 4'd3)) begin
                errors++;
                $display("FAIL single c=%0d v=%b id=%0d oh=%h want v=%0d id=3",
                         c, bus.grant_valid, bus.grant_id, bus.grant_onehot, want_v[c]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        req = 16'h0104; ready = 1'b0;
        step();
        flush = 1'b1; ready = 1'b1;
        step();
        flush = 1'b0; ready = 1'b0;
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 16'h0) begin
            errors++;
            $display("FAIL flush v=%b oh=%h want 0/0", bus.grant_valid, bus.grant_onehot);
        end
        step();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== 4'd8) begin
            errors++;
            $display("FAIL flush_ptr v=%b id=%0d want 1/8", bus.grant_valid, bus.grant_id);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; req = 16'h0;
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant_id !== 4'd0 ||
            bus.grant_onehot !== 16'h0) begin
            errors++;
            $display("FAIL rst_hold v=%b id=%0d oh=%h want 0/0/0",
                     bus.grant_valid, bus.grant_id, bus.grant_onehot);
        end
`ifdef WF_ARB_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_stall got %0d want 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req   = 16'($urandom) & 16'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            step();
            checks++;
            if (bus.grant_valid !== mv || bus.grant_onehot !== model_oh() ||
                (mv && int'(bus.grant_id) != mid)) begin
                errors++;
                $display("FAIL random c=%0d v=%b id=%0d oh=%h want v=%0d id=%0d",
                         c, bus.grant_valid, bus.grant_id, bus.grant_onehot, mv, mid);
            end
`ifdef WF_ARB_PERF_CNT_EN
            checks++;
            if (stall_cnt !== mstall) begin
                errors++;
                $display("FAIL random_stall got %0d want %0d", stall_cnt, mstall);
            end
`endif
        end
        flush = 1'b0;
    endtask

    initial begin
        mv = 0; mid = 0; mptr = 0; mstall = 0;
        rst = 1'b1; req = 16'h0; flush = 1'b0; ready = 1'b0;
        test_reset();
        test_alternate();
        test_stall();
        test_wrap();
        test_single();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
